cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Initiator-side bridge between the L2/last-level cache and the burst-mode physical memory model. It converts a single 256-bit cacheline read or write from the cache into a 4-beat, 64-bit burst on the memory port. It then returns a one-cycle completion to the cache. It is the host end of the same burst protocol the parameterised memory responder implements. It is instantiated in the DUT between the cache and `mem_itf`.

## Interface
- `LINE_W`, 256, cacheline width in bits
- `BURST_W`, 64, burst beat width; `BEATS = LINE_W/BURST_W` (4), must be a power of two
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `line_i`  in  LINE_W  write line from cache, sampled at request acceptance
- `line_o`  out  LINE_W  read line to cache, valid when `resp_o`=1, held until next read completes
- `address_i`  in  32  cache request address
- `read_i`  in  1  cache read request, level, held until `resp_o`
- `write_i`  in  1  cache write request, level, held until `resp_o`
- `resp_o`  out  1  one-cycle completion pulse
- `burst_i`  in  BURST_W  read beat from memory
- `burst_o`  out  BURST_W  write beat to memory
- `address_o`  out  32  line-aligned memory address
- `read_o`  out  1  memory read request
- `write_o`  out  1  memory write request
- `resp_i`  in  1  memory beat strobe: one pulse per beat

## Operation
- The FSM has four states: IDLE, READ, WRITE, DONE. A 2-bit beat counter `cnt` tracks progress through the burst.
- IDLE:
  - If `write_i`=1, latch `line_i` into `wbuf` and set `addr_q = {address_i[31:5], 5'b0}`. Then `cnt` <= 0 and go to WRITE.
  - Otherwise, if `read_i`=1, latch the address the same way, set `cnt` <= 0 and go to READ.
  - If both `read_i` and `write_i` are high, write wins.
  - Any `resp_i` seen in IDLE or DONE is ignored.
- READ:
  - `read_o`=1 and `address_o`=`addr_q`.
  - On each cycle with `resp_i`=1, store `burst_i` into `rbuf[cnt*BURST_W +: BURST_W]` and increment `cnt`. Beat 0 is the least significant 64 bits.
  - Gaps between beats are tolerated; `cnt` holds while `resp_i`=0.
  - On the beat where `cnt`=BEATS-1, go to DONE.
- WRITE:
  - `write_o`=1, `address_o`=`addr_q`, and `burst_o = wbuf[cnt*BURST_W +: BURST_W]` (combinational from `cnt`).
  - Each `resp_i` accepts the current beat and increments `cnt`.
  - On the last beat, go to DONE.
- DONE: `resp_o`=1 for exactly one cycle, then return to IDLE unconditionally. New requests are not sampled in DONE.
- `line_o` is driven from `rbuf` at all times. `rbuf` changes only during READ beats.
- `cnt` wraps from BEATS-1 to 0 on the final beat. No overflow state exists.
- `read_o` and `write_o` are never high together. Each stays continuously high from the first request cycle through the cycle of the last `resp_i`.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from `read_i`, `write_i` or `resp_i` to any output.
- Reset values: FSM=IDLE, `cnt`=0, `addr_q`=0, `rbuf`=0, `wbuf`=0. Consequently `resp_o`=0, `read_o`=0, `write_o`=0, `address_o`=0, `burst_o`=0, `line_o`=0.
- Request issue: cache request high in cycle N means `read_o`/`write_o` is high in cycle N+1.
- Completion: last `resp_i` in cycle M means `read_o`/`write_o` is low and `resp_o`=1 in cycle M+1. `line_o` holds the full line in cycle M+1.
- Adaptor overhead is 2 cycles: 1 to issue, 1 to complete. Total latency = memory latency + BEATS + 2 with back-to-back beats.
- Back-to-back requests: earliest re-issue is cycle M+2 (DONE→IDLE→request).
- Reset asserted mid-burst: all outputs clear asynchronously and partial `rbuf` data is discarded. After release, the FSM is in IDLE and requires a fresh request.
- `address_i[4:0]` is ignored. `address_o[4:0]` is always 0.

## Test plan
- Reset: assert `rst`=0 mid-READ after 2 beats. Required: `read_o`=0 immediately, `line_o`=0, FSM returns to IDLE. A subsequent read completes normally.
- Read: `read_i`=1, `address_i`=0x0000_1234. Memory returns beats 0x11…11, 0x22…22, 0x33…33, 0x44…44 on consecutive `resp_i`. Required: `address_o`=0x0000_1220; `resp_o` for one cycle after beat 4; `line_o`={0x44…44, 0x33…33, 0x22…22, 0x11…11}.
- Write: `write_i`=1, `line_i`={D3,D2,D1,D0}. Required: `burst_o` shows D0, D1, D2, D3 on successive `resp_i`; `write_o` drops and `resp_o`=1 the cycle after the 4th beat.
- Gapped beats: insert 3 idle cycles between `resp_i` beats 1 and 2 of a read. Required: `cnt` holds, the line is assembled correctly, and `resp_o` fires only after 4 beats.
- Simultaneous request: `read_i`=`write_i`=1. Required: only `write_o` is asserted and `rbuf` is unchanged.
- Back-to-back: a read immediately followed by a write using the ParamMemory model (latency 50/25). Required: zero shadow-memory mismatches, and `read_o`/`write_o` never overlap.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor_if
//
// Groups every signal between the cacheline adaptor, the cache above it and
// the burst memory below it. Signal names keep the adaptor-centric _i/_o
// suffixes. A signal ending in _i is driven into the adaptor. A signal ending
// in _o is driven by the adaptor.
//
// Modports:
//   master : the adaptor itself. It is the burst initiator on the memory side
//            and the responder on the cache side.
//   slave  : the environment, meaning the cache plus the memory model.
//
// Signals:
//   line_i    [LINE_W]  write line from cache
//   line_o    [LINE_W]  read line to cache
//   address_i [32]      cache request address
//   read_i              cache read request (level)
//   write_i             cache write request (level)
//   resp_o              one-cycle completion to cache
//   burst_i   [BURST_W] read beat from memory
//   burst_o   [BURST_W] write beat to memory
//   address_o [32]      line-aligned memory address
//   read_o              memory read request
//   write_o             memory write request
//   resp_i              memory beat strobe
// -----------------------------------------------------------------------------
interface cacheline_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
);
    // cache side
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;

    // memory side
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport master (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport slave (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface : cacheline_adaptor_if

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Sits between the last-level cache and the burst-mode memory. It turns one
// LINE_W-bit cacheline read or write into a burst of BEATS beats, each
// BURST_W bits wide. When the burst is finished it returns a one-cycle
// completion pulse to the cache.
//
// Ports:
//   clk  single clock; all state updates on the rising edge
//   rst  asynchronous, active-low reset
//   bus  cacheline_adaptor_if.master (cache side plus memory side)
//
// Behaviour:
//   IDLE  : Samples the cache request. A write wins over a read. The address
//           is latched line-aligned. A write also latches the line into wbuf.
//   READ  : Holds read_o high. Each resp_i stores burst_i into rbuf slot cnt.
//   WRITE : Holds write_o high. burst_o presents wbuf slot cnt. Each resp_i
//           advances cnt to the next slot.
//   DONE  : Pulses resp_o for one cycle, then returns to IDLE. No request is
//           sampled in this state.
//
// All outputs are decoded from registered state. No input has a
// combinational path to any output.
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.master bus
);

    localparam int BEATS    = LINE_W / BURST_W;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_W / 8);   // byte offset within a line

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_q;
    logic [LINE_W-1:0]  rbuf;
    logic [LINE_W-1:0]  wbuf;

    logic [31:0]        line_addr;
    logic               last_beat;

    // The request address with the in-line byte offset cleared.
    assign line_addr = {bus.address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};

    // A beat strobe that lands on the final slot closes the burst.
    assign last_beat = bus.resp_i && (cnt == CNT_W'(BEATS - 1));

    // The low address bits are dropped on purpose. Tying them into a sink
    // signal records that they are deliberately unused.
    logic unused_offset;
    assign unused_offset = ^bus.address_i[OFFSET_W-1:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) assignments. Every flop then
    // samples pre-edge values, whatever order the processes run in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case. Every path then
    // assigns it, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.write_i) begin
                    state_next = WRITE;
                end else if (bus.read_i) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: beat counter, address and line buffers
    // -------------------------------------------------------------------------
    // NOTE: rbuf and wbuf are plain flop arrays, not RAM macros. They are
    // reset so that line_o and burst_o read as zero after reset, and so that a
    // read interrupted by reset leaves no partial data behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            addr_q <= '0;
            rbuf   <= '0;
            wbuf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write_i) begin
                        wbuf   <= bus.line_i;
                        addr_q <= line_addr;
                        cnt    <= '0;
                    end else if (bus.read_i) begin
                        addr_q <= line_addr;
                        cnt    <= '0;
                    end
                end
                READ: begin
                    // Beat 0 fills the least significant slice. On the final
                    // beat cnt wraps back to zero.
                    if (bus.resp_i) begin
                        rbuf[cnt*BURST_W +: BURST_W] <= bus.burst_i;
                        cnt                          <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Nothing is sampled while the completion pulse is out.
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        bus.read_o    = 1'b0;
        bus.write_o   = 1'b0;
        bus.resp_o    = 1'b0;
        bus.address_o = addr_q;
        bus.line_o    = rbuf;
        // The write beat follows cnt directly. The next beat is therefore
        // already on the bus in the cycle after memory accepts one.
        bus.burst_o   = wbuf[cnt*BURST_W +: BURST_W];
        case (state)
            READ:    bus.read_o  = 1'b1;
            WRITE:   bus.write_o = 1'b1;
            DONE:    bus.resp_o  = 1'b1;
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    a_no_overlap : assert property (@(posedge clk) disable iff (!rst)
        !(bus.read_o && bus.write_o));

    a_addr_aligned : assert property (@(posedge clk) disable iff (!rst)
        bus.address_o[OFFSET_W-1:0] == '0);

    a_resp_single : assert property (@(posedge clk) disable iff (!rst)
        bus.resp_o |=> !bus.resp_o);

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Drives the adaptor from the cache side and plays the burst memory. The
// bench's memory is a line-granular shadow array. Expected read lines come
// from that array. Expected write beats are computed by shifting the
// requested line right by 64 bits per beat.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    // The line the cache should currently see on line_o.
    logic [LINE_W-1:0] last_rd;

    // The shadow memory, keyed by line-aligned address.
    logic [LINE_W-1:0] shadow [int unsigned];

    cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W)) bus ();

    cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard. Every wait below is a fixed cycle count.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BURST_W-1:0] junk();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One complete cache transaction. It starts and ends at a falling edge
    // while the adaptor is idle. For a read, 'line' is the content the memory
    // returns. For a write, it is the line the cache supplies. g0..g3 are the
    // idle cycles inserted before each beat; g0 acts as the memory latency.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [LINE_W-1:0] line,
                           input int g0, input int g1, input int g2, input int g3);
        int                 gaps[4];
        bit                 exp_wr;
        bit                 exp_rd;
        logic [31:0]        exp_addr;
        logic [BURST_W-1:0] beat;
        gaps     = '{g0, g1, g2, g3};
        exp_wr   = wr;
        exp_rd   = rd && !wr;
        exp_addr = addr & 32'hFFFF_FFE0;

        check("idle_before_req", {bus.read_o, bus.write_o, bus.resp_o}, '0);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.line_i    = line;
        @(negedge clk);
        check("issue_read_o",  bus.read_o,    exp_rd);
        check("issue_write_o", bus.write_o,   exp_wr);
        check("address_o",     bus.address_o, exp_addr);

        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = junk();
                @(negedge clk);
                check("gap_busy", {bus.read_o, bus.write_o, bus.resp_o},
                      {exp_rd, exp_wr, 1'b0});
            end
            beat = BURST_W'(line >> (BURST_W * b));
            if (wr) check($sformatf("burst_o_beat%0d", b), bus.burst_o, beat);
            bus.resp_i  = 1'b1;
            bus.burst_i = wr ? junk() : beat;
            @(negedge clk);
            bus.resp_i  = 1'b0;
            bus.burst_i = junk();
            if (b < 3)
                check("beat_busy", {bus.read_o, bus.write_o, bus.resp_o},
                      {exp_rd, exp_wr, 1'b0});
        end

        // The cycle after the last beat: request lines drop, completion pulses.
        check("done_outputs", {bus.read_o, bus.write_o, bus.resp_o}, 3'b001);
        if (!wr) last_rd = line;
        check("line_o_done", bus.line_o, last_rd);

        // The request is still held through the DONE cycle, and it must not
        // be picked up there.
        @(negedge clk);
        check("after_done_idle", {bus.read_o, bus.write_o, bus.resp_o}, '0);
        check("line_o_hold", bus.line_o, last_rd);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
    endtask

    typedef struct {
        bit                wr;
        bit                rd;
        logic [31:0]       addr;
        logic [LINE_W-1:0] line;
        int                g0, g1, g2, g3;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        last_rd       = '0;

        // Directed vectors.
        vecs[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_1234,
                    line: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
                    g0: 0, g1: 0, g2: 0, g3: 0};
        vecs[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'hDEAD_BEEF,
                    line: {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
                           64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000},
                    g0: 0, g1: 0, g2: 0, g3: 0};
        vecs[2] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_00FF,
                    line: {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                           64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001},
                    g0: 2, g1: 3, g2: 0, g3: 1};
        vecs[3] = '{wr: 1'b1, rd: 1'b1, addr: 32'h8000_001F,
                    line: {4{64'h0123_4567_89AB_CDEF}},
                    g0: 1, g1: 0, g2: 0, g3: 0};
        vecs[4] = '{wr: 1'b0, rd: 1'b1, addr: 32'hFFFF_FFFF,
                    line: {32{8'hA5}},
                    g0: 0, g1: 1, g2: 0, g3: 0};
        vecs[5] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_0020,
                    line: {64'h4444_0000_0000_0000, 64'h0000_3333_0000_0000,
                           64'h0000_0000_2222_0000, 64'h0000_0000_0000_1111},
                    g0: 1, g1: 1, g2: 1, g3: 1};

        // Reset: create a real falling edge, then look at the reset values.
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, '0);
        check("rst_address_o", bus.address_o, '0);
        check("rst_burst_o",   bus.burst_o,   '0);
        check("rst_line_o",    bus.line_o,    '0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven directed transactions.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].line,
                    vecs[i].g0, vecs[i].g1, vecs[i].g2, vecs[i].g3);
        end

        // Stray beat strobes while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = junk();
            @(negedge clk);
            check("stray_resp_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, '0);
            check("stray_resp_line", bus.line_o, last_rd);
        end
        bus.resp_i = 1'b0;

        // Reset in the middle of a read, after two beats.
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_0040;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {16{4'hB}};
            @(negedge clk);
        end
        bus.resp_i = 1'b0;
        check("pre_rst_read_o", bus.read_o, 1'b1);
        #2;
        rst         = 1'b0;
        bus.read_i  = 1'b0;
        #1;
        check("midrst_read_o",    bus.read_o,    1'b0);
        check("midrst_resp_o",    bus.resp_o,    1'b0);
        check("midrst_address_o", bus.address_o, '0);
        check("midrst_line_o",    bus.line_o,    '0);
        last_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {bus.read_o, bus.write_o, bus.resp_o}, '0);
        run_txn(1'b0, 1'b1, 32'h0000_0044, {8{32'h5A5A_0F0F}}, 0, 0, 0, 0);

        // Back-to-back: a read with latency 50, then at once a write with
        // latency 25.
        run_txn(1'b0, 1'b1, 32'h0000_1000, rand_line(), 50, 0, 0, 0);
        run_txn(1'b1, 1'b0, 32'h0000_2000, rand_line(), 25, 0, 0, 0);

        // Randomised traffic against the shadow memory.
        for (int t = 0; t < 60; t++) begin
            int unsigned       base;
            int unsigned       op;
            logic [31:0]       a;
            logic [LINE_W-1:0] data;
            case ($urandom_range(0, 3))
                0:       base = 32'h0000_0100;
                1:       base = 32'h0000_2000;
                2:       base = 32'h0003_0000;
                default: base = 32'hFFFF_FFE0;
            endcase
            a  = base | 32'($urandom_range(0, 31));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                if (!shadow.exists(base)) shadow[base] = rand_line();
                data = shadow[base];
                run_txn(1'b0, 1'b1, a, data, $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3));
            end else begin
                data = rand_line();
                shadow[base] = data;
                run_txn(1'b1, op == 2, a, data, $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cacheline_adaptor
